dec416: RTL and testbench
=========================

DEC416 -- requirements
Module: dec416

Interface
REQ-001 Parameter OUT_ACTIVE_LOW, default 0: output polarity; 0 means the selected output is 1, 1 means all outputs are inverted.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port a, input, 1 bit: select bit 3 (MSB).
REQ-005 Port b, input, 1 bit: select bit 2.
REQ-006 Port c, input, 1 bit: select bit 1.
REQ-007 Port d, input, 1 bit: select bit 0 (LSB).
REQ-008 Port en, input, 1 bit: decode enable; 1 means decode, 0 means all outputs inactive.
REQ-009 Ports y0..y15, output, 1 bit each: decoded lines; yN corresponds to select value N = {a,b,c,d}.
REQ-010 Port order: clk, rst_n, a, b, c, d, en, y0..y15.

Function
REQ-011 sel = {a,b,c,d}, an unsigned 4-bit value in the range 0..15.
REQ-012 When en=1, exactly one output, y[sel], SHALL be active and the other 15 inactive (one-hot).
REQ-013 When en=0, all 16 outputs SHALL be inactive.
REQ-014 Outputs SHALL be registered: the value sampled at rising edge k appears on the outputs after edge k, with 1-cycle latency.
REQ-015 Active level is 1 and inactive level is 0 when OUT_ACTIVE_LOW=0; the levels are swapped when OUT_ACTIVE_LOW=1.
REQ-016 Inputs that change between edges SHALL have no effect until the next rising edge; outputs have no glitches.
REQ-017 When sel changes every cycle, the outputs SHALL follow every cycle with no holes or duplicates.
REQ-018 If any select bit or en is X/Z, the behaviour is don't-care for synthesis, but the simulation model SHALL drive all outputs inactive.
REQ-019 Wrap-around: sel stepping 15 -> 0 SHALL move the active line from y15 to y0 in a single cycle.

Reset
REQ-020 While rst_n=0, all outputs SHALL be at the inactive level (0 if OUT_ACTIVE_LOW=0, else 1), immediately and without a clock edge.
REQ-021 Reset asserted mid-operation SHALL clear the outputs asynchronously.
REQ-022 After rst_n deasserts, the first rising edge SHALL load the decode of the current inputs.
REQ-023 Reset release SHALL be synchronized externally; no internal synchronizer is required.

Structure
REQ-024 The shared package dec416_pkg SHALL hold SEL_W=4 and NUM_OUT=16, plus a helper that converts a select value to a one-hot vector.
REQ-025 Natural sub-module dec2to4 (2 select bits, enable, 4 one-hot outputs): the top level uses one instance for {a,b} to produce group enables and four instances for {c,d}.
REQ-026 Decode logic SHALL be combinational, feeding a single 16-bit output register.
REQ-027 The polarity inversion SHALL be applied at the register output stage.

Verification
REQ-028 Sweep: rst_n=1, en=1, a/b/c/d toggling as a binary counter 0..15 (d fastest), one value per cycle -> one cycle later only y[sel] is 1; sel=0 gives y0=1, sel=15 gives y15=1.
REQ-029 Enable: sel=9, en=0 -> all outputs 0; en set to 1 -> y9=1 after the next edge.
REQ-030 Async reset: sel=5 with y5=1, rst_n pulled to 0 between edges -> y5=0 at once; rst_n=1 -> y5=1 after the next edge.
REQ-031 Polarity: OUT_ACTIVE_LOW=1 and sel=3 -> y3=0, other 15 outputs =1; in reset all =1.
REQ-032 Latency and wrap: sel 15 -> 0 across one edge -> y15 drops and y0 rises on the same cycle; an input change between edges produces no output change.
REQ-033 Checker: on every cycle, the count of active outputs SHALL be 1 when en=1 and 0 when en=0.

Source files
------------

// File: rtl/dec416_pkg.sv
// Shared constants, types and a select-to-one-hot helper for the 4-to-16 decoder.
package dec416_pkg;

    localparam int SEL_W   = 4;
    localparam int NUM_OUT = 16;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [NUM_OUT-1:0] onehot_t;

    function automatic onehot_t sel_to_onehot(input sel_t sel);
        onehot_t v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec416_if.sv
// Bundle of the decoder's select/enable inputs and its 16 decoded output lines.
interface dec416_if;
    import dec416_pkg::*;

    logic         a;
    logic         b;
    logic         c;
    logic         d;
    logic         en;
    wire  [NUM_OUT-1:0] y;

    modport master (output a, output b, output c, output d, output en, input y);
    modport slave  (input a, input b, input c, input d, input en, output y);

endinterface

// File: rtl/dec416_dec2to4.sv
// 2-to-4 one-hot decoder with enable; building block of the two-level 4-to-16 tree.
module dec2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/dec416.sv
// Registered 4-to-16 decoder: {a,b} picks a group of four, {c,d} picks the line within it.
module dec416
    import dec416_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic en,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic y4,
    output logic y5,
    output logic y6,
    output logic y7,
    output logic y8,
    output logic y9,
    output logic y10,
    output logic y11,
    output logic y12,
    output logic y13,
    output logic y14,
    output logic y15
);

    sel_t    sel;
    logic    in_unknown;
    logic [3:0] grp_en;
    onehot_t dec_onehot;
    onehot_t y_d;
    onehot_t y_q;
    onehot_t y_out;

    assign sel = {a, b, c, d};

    dec2to4 u_grp (
        .sel (sel[3:2]),
        .en  (en),
        .y   (grp_en)
    );

    for (genvar g = 0; g < 4; g++) begin : g_low
        dec2to4 u_low (
            .sel (sel[1:0]),
            .en  (grp_en[g]),
            .y   (dec_onehot[g*4 +: 4])
        );
    end

    // Unknown selects or enable park every line inactive in simulation.
    always_comb begin
        in_unknown = $isunknown({sel, en});
        y_d        = dec_onehot;
        if (in_unknown) begin
            y_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    // y_q holds active-high one-hot; polarity is flipped only after the register.
    assign y_out = y_q ^ {NUM_OUT{OUT_ACTIVE_LOW}};

    assign y0  = y_out[0];
    assign y1  = y_out[1];
    assign y2  = y_out[2];
    assign y3  = y_out[3];
    assign y4  = y_out[4];
    assign y5  = y_out[5];
    assign y6  = y_out[6];
    assign y7  = y_out[7];
    assign y8  = y_out[8];
    assign y9  = y_out[9];
    assign y10 = y_out[10];
    assign y11 = y_out[11];
    assign y12 = y_out[12];
    assign y13 = y_out[13];
    assign y14 = y_out[14];
    assign y15 = y_out[15];

endmodule

// File: tb/tb_dec416.sv
// Scoreboard bench for dec416: active-high and active-low instances share one stimulus stream.
module tb_dec416;
    import dec416_pkg::*;

    logic clk;
    logic rst_n;
    dec416_if bus ();
    wire [15:0] y_al;

    int assert_count = 0;
    int fail_count   = 0;
    logic [15:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dec416 #(.OUT_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(bus.a), .b(bus.b), .c(bus.c), .d(bus.d), .en(bus.en),
        .y0(bus.y[0]),   .y1(bus.y[1]),   .y2(bus.y[2]),   .y3(bus.y[3]),
        .y4(bus.y[4]),   .y5(bus.y[5]),   .y6(bus.y[6]),   .y7(bus.y[7]),
        .y8(bus.y[8]),   .y9(bus.y[9]),   .y10(bus.y[10]), .y11(bus.y[11]),
        .y12(bus.y[12]), .y13(bus.y[13]), .y14(bus.y[14]), .y15(bus.y[15])
    );

    dec416 #(.OUT_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n),
        .a(bus.a), .b(bus.b), .c(bus.c), .d(bus.d), .en(bus.en),
        .y0(y_al[0]),   .y1(y_al[1]),   .y2(y_al[2]),   .y3(y_al[3]),
        .y4(y_al[4]),   .y5(y_al[5]),   .y6(y_al[6]),   .y7(y_al[7]),
        .y8(y_al[8]),   .y9(y_al[9]),   .y10(y_al[10]), .y11(y_al[11]),
        .y12(y_al[12]), .y13(y_al[13]), .y14(y_al[14]), .y15(y_al[15])
    );

    function automatic logic [15:0] expectedLines(input logic [3:0] sel, input logic enable);
        logic [15:0] v;
        v = 16'h0000;
        if (enable) v = 16'h0001 << sel;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive on the falling edge so the next rising edge samples stable inputs.
    task automatic applyStimulus(input logic [3:0] sel, input logic enable);
        @(negedge clk);
        bus.a  = sel[3];
        bus.b  = sel[2];
        bus.c  = sel[1];
        bus.d  = sel[0];
        bus.en = enable;
        exp_q.push_back(expectedLines(sel, enable));
    endtask

    task automatic checkCycle(input string tag);
        logic [15:0] exp_v;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL %s: scoreboard empty, got %h", tag, bus.y);
        end else begin
            exp_v = exp_q.pop_front();
            checkOutput(tag, bus.y, exp_v);
            checkOutput({tag, "_al"}, y_al, ~exp_v);
            checkOutput({tag, "_cnt"}, 16'($countones(bus.y)), 16'($countones(exp_v)));
        end
    endtask

    initial begin
        logic [3:0]  rsel;
        logic        ren;
        logic [15:0] held;

        rst_n  = 1'b1;
        bus.a  = 1'b0;
        bus.b  = 1'b0;
        bus.c  = 1'b0;
        bus.d  = 1'b1;
        bus.en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_hi", bus.y, 16'h0000);
        checkOutput("reset_lo", y_al, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold_hi", bus.y, 16'h0000);
        checkOutput("reset_hold_lo", y_al, 16'hFFFF);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("release_no_edge", bus.y, 16'h0000);

        for (int s = 0; s < 16; s++) begin
            applyStimulus(4'(s), 1'b1);
            checkCycle($sformatf("sweep%0d", s));
        end

        applyStimulus(4'd15, 1'b1);
        checkCycle("wrap15");
        applyStimulus(4'd0, 1'b1);
        checkCycle("wrap0");

        applyStimulus(4'd9, 1'b0);
        checkCycle("en_off9");
        applyStimulus(4'd9, 1'b1);
        checkCycle("en_on9");

        applyStimulus(4'd3, 1'b1);
        checkCycle("pol3");

        applyStimulus(4'd5, 1'b1);
        checkCycle("pre_reset5");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_hi", bus.y, 16'h0000);
        checkOutput("async_reset_lo", y_al, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(expectedLines(4'd5, 1'b1));
        #1;
        checkOutput("after_release", bus.y, 16'h0000);
        checkCycle("first_edge5");

        held  = bus.y;
        bus.a = 1'b1;
        bus.c = 1'b1;
        #2;
        checkOutput("mid_cycle_hold", bus.y, 16'h0020);
        checkOutput("mid_cycle_hold_lo", y_al, ~held);

        for (int i = 0; i < 24; i++) begin
            rsel = 4'($urandom_range(0, 15));
            ren  = ($urandom_range(0, 3) != 0);
            applyStimulus(rsel, ren);
            checkCycle($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
